// File: rtl/addsub_cmd_seq_4bit.sv
// addsub_cmd_seq_4bit
// Sequential command front-end for the external combinational 4-bit
// adder/subtractor. Commands {op, use_acc, a, b} are buffered in a small FIFO.
// They are issued one at a time through registered ext_a/ext_b/ext_cin. The
// unit's result/cout is captured one cycle later, and results are returned
// with status flags over a valid/ready handshake.
//
// Optional feature: define ADDSUB_SAT_EN for unsigned saturation of the
// captured result. An add with carry gives 4'hF. A subtract with borrow
// gives 4'h0.
`timescale 1ns/1ps

module addsub_cmd_seq_4bit #(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  // command input
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  input  logic       in_op,
  input  logic       in_use_acc,
  // adder/subtractor operand drive
  output logic [3:0] ext_a,
  output logic [3:0] ext_b,
  output logic       ext_cin,
  // adder/subtractor outputs
  input  logic [3:0] ext_result,
  input  logic       ext_cout,
  // result output
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_result,
  output logic       out_carry,
  output logic       out_zero,
  output logic       out_ovf,
  // status
  output logic [3:0] acc_out,
  output logic       busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int ENTRY_W = 10;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] rd_entry;
  logic               rd_op;
  logic               rd_use_acc;
  logic [3:0]         rd_a;
  logic [3:0]         rd_b;

  // ---------------------------------------------------------------------------
  // FSM, issue registers and result registers
  // ---------------------------------------------------------------------------
  logic [1:0] state_q, state_d;
  logic [3:0] ext_a_q, ext_a_d;
  logic [3:0] ext_b_q, ext_b_d;
  logic       ext_cin_q, ext_cin_d;
  logic       op_q, op_d;
  logic       use_acc_q, use_acc_d;
  logic [3:0] acc_q, acc_d;
  logic       out_valid_q, out_valid_d;
  logic [3:0] out_result_q, out_result_d;
  logic       out_carry_q, out_carry_d;
  logic       out_zero_q, out_zero_d;
  logic       out_ovf_q, out_ovf_d;

  // Capture-stage values derived from the unit's settled outputs
  logic [3:0] beff;
  logic       cap_carry;
  logic       cap_ovf;
  logic [3:0] cap_result;

  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);
  assign in_ready   = !fifo_full;
  assign push       = in_valid && !fifo_full;
  assign pop        = (state_q == ST_IDLE) && !fifo_empty;

  assign rd_entry   = mem_q[rd_ptr_q];
  assign rd_op      = rd_entry[9];
  assign rd_use_acc = rd_entry[8];
  assign rd_a       = rd_entry[7:4];
  assign rd_b       = rd_entry[3:0];

  // Command storage: written on push, read at the current read pointer
  // NOTE: the storage array has no reset. Only entries between rd_ptr and
  // wr_ptr are ever read, and count is reset, so stale data is never used.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_op, in_use_acc, in_a, in_b};
    end
  end

  // Next pointers and occupancy. A power-of-two depth lets the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Result, carry/borrow and signed-overflow flags from the unit's outputs
  always_comb begin
    beff      = ext_b_q ^ {4{op_q}};
    cap_carry = op_q ? ~ext_cout : ext_cout;
    cap_ovf   = (ext_a_q[3] == beff[3]) && (ext_result[3] != ext_a_q[3]);
`ifdef ADDSUB_SAT_EN
    // Saturate on unsigned overflow (add) or underflow (sub); flags stay raw.
    if (!op_q && ext_cout) begin
      cap_result = 4'hF;
    end else if (op_q && !ext_cout) begin
      cap_result = 4'h0;
    end else begin
      cap_result = ext_result;
    end
`else
    cap_result = ext_result;
`endif
  end

  // Sequencer: IDLE pops and issues, EXEC captures, DONE waits for the consumer
  // NOTE: every variable gets a default (hold) value first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    ext_a_d      = ext_a_q;
    ext_b_d      = ext_b_q;
    ext_cin_d    = ext_cin_q;
    op_d         = op_q;
    use_acc_d    = use_acc_q;
    acc_d        = acc_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_carry_d  = out_carry_q;
    out_zero_d   = out_zero_q;
    out_ovf_d    = out_ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          // Read the accumulator now, not at push time, so queued chains work.
          ext_a_d   = rd_use_acc ? acc_q : rd_a;
          ext_b_d   = rd_b;
          ext_cin_d = rd_op;
          op_d      = rd_op;
          use_acc_d = rd_use_acc;
          state_d   = ST_EXEC;
        end
      end

      ST_EXEC: begin
        out_result_d = cap_result;
        out_carry_d  = cap_carry;
        out_zero_d   = (cap_result == 4'h0);
        out_ovf_d    = cap_ovf;
        out_valid_d  = 1'b1;
        if (use_acc_q) begin
          acc_d = cap_result;
        end
        state_d = ST_DONE;
      end

      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset
  // NOTE: sequential state uses non-blocking assignments only. All flops
  // update together from the values they held before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= ST_IDLE;
      ext_a_q      <= '0;
      ext_b_q      <= '0;
      ext_cin_q    <= 1'b0;
      op_q         <= 1'b0;
      use_acc_q    <= 1'b0;
      acc_q        <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_carry_q  <= 1'b0;
      out_zero_q   <= 1'b0;
      out_ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      ext_a_q      <= ext_a_d;
      ext_b_q      <= ext_b_d;
      ext_cin_q    <= ext_cin_d;
      op_q         <= op_d;
      use_acc_q    <= use_acc_d;
      acc_q        <= acc_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_carry_q  <= out_carry_d;
      out_zero_q   <= out_zero_d;
      out_ovf_q    <= out_ovf_d;
    end
  end

  assign ext_a      = ext_a_q;
  assign ext_b      = ext_b_q;
  assign ext_cin    = ext_cin_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_carry  = out_carry_q;
  assign out_zero   = out_zero_q;
  assign out_ovf    = out_ovf_q;
  assign acc_out    = acc_q;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_addsub_cmd_seq_4bit.sv
// tb_addsub_cmd_seq_4bit
// Scoreboard bench for addsub_cmd_seq_4bit. A behavioural 4-bit
// adder/subtractor closes the ext_* loop. Expected responses are computed
// with plain integer arithmetic when a command is accepted. A monitor
// compares them whenever the DUT completes an output handshake.
`timescale 1ns/1ps

module tb_addsub_cmd_seq_4bit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic       in_op = 1'b0;
  logic       in_use_acc = 1'b0;
  logic [3:0] ext_a;
  logic [3:0] ext_b;
  logic       ext_cin;
  logic [3:0] ext_result;
  logic       ext_cout;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_result;
  logic       out_carry;
  logic       out_zero;
  logic       out_ovf;
  logic [3:0] acc_out;
  logic       busy;

  addsub_cmd_seq_4bit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .in_use_acc (in_use_acc),
    .ext_a      (ext_a),
    .ext_b      (ext_b),
    .ext_cin    (ext_cin),
    .ext_result (ext_result),
    .ext_cout   (ext_cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_zero   (out_zero),
    .out_ovf    (out_ovf),
    .acc_out    (acc_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // The team's combinational adder/subtractor: cin=1 inverts b and adds 1.
  logic [4:0] unit_sum;
  assign unit_sum   = {1'b0, ext_a} + {1'b0, (ext_b ^ {4{ext_cin}})} + {4'b0, ext_cin};
  assign ext_result = unit_sum[3:0];
  assign ext_cout   = unit_sum[4];

  typedef struct packed {
    logic [3:0] res;
    logic       carry;
    logic       zero;
    logic       ovf;
    logic [3:0] acc;
    logic [3:0] ea;
    logic [3:0] eb;
    logic       ecin;
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] acc_m = '0;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result computed from integer arithmetic on the issued operands
  task automatic predict(input logic op, input logic use_acc, input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    int   ua, ub, sa, sbv, ur, sr;
    e.ea   = use_acc ? acc_m : a;
    e.eb   = b;
    e.ecin = op;
    ua  = int'(e.ea);
    ub  = int'(b);
    sa  = int'($signed(e.ea));
    sbv = int'($signed(b));
    if (!op) begin
      ur      = ua + ub;
      sr      = sa + sbv;
      e.carry = (ur > 15);
    end else begin
      ur      = ua - ub;
      sr      = sa - sbv;
      e.carry = (ua < ub);
    end
    e.res = ur[3:0];
`ifdef ADDSUB_SAT_EN
    if (e.carry) begin
      e.res = op ? 4'h0 : 4'hF;
    end
`endif
    e.ovf  = (sr > 7) || (sr < -8);
    e.zero = (e.res == 4'h0);
    if (use_acc) begin
      acc_m = e.res;
    end
    e.acc = acc_m;
    sb_q.push_back(e);
  endtask

  // Present one command and hold it until accepted. The expected response is queued on acceptance.
  task automatic push(input logic op, input logic use_acc, input logic [3:0] a, input logic [3:0] b,
                      output int waited);
    logic accepted;
    accepted   = 1'b0;
    in_valid   = 1'b1;
    in_op      = op;
    in_use_acc = use_acc;
    in_a       = a;
    in_b       = b;
    for (waited = 0; waited < 60; waited++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        accepted = 1'b1;
        break;
      end
    end
    if (accepted) begin
      predict(op, use_acc, a, b);
    end else begin
      check("push_timeout", 32'(in_ready), 32'(1'b1));
    end
    in_valid = 1'b0;
  endtask

  // Wait for the scoreboard to empty and the DUT to go idle, within a cycle budget
  task automatic drain();
    int cyc;
    for (cyc = 0; cyc < 200; cyc++) begin
      if (sb_q.size() == 0 && !busy) break;
      @(posedge clk);
      #1;
    end
    if (cyc >= 200) begin
      check("drain_timeout_pending", 32'(sb_q.size()), 32'(0));
    end
  endtask

  // Monitor: compare each completed output handshake against the next expected entry
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", 32'(out_valid), 32'(1'b0));
        end else begin
          e = sb_q.pop_front();
          check("out_result", 32'(out_result), 32'(e.res));
          check("out_carry",  32'(out_carry),  32'(e.carry));
          check("out_zero",   32'(out_zero),   32'(e.zero));
          check("out_ovf",    32'(out_ovf),    32'(e.ovf));
          check("acc_out",    32'(acc_out),    32'(e.acc));
          check("ext_a",      32'(ext_a),      32'(e.ea));
          check("ext_b",      32'(ext_b),      32'(e.eb));
          check("ext_cin",    32'(ext_cin),    32'(e.ecin));
        end
      end
    end
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Directed stimulus
  initial begin
    int w;
    int lat;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(1'b0));
    check("rst_out_result", 32'(out_result), 32'(4'h0));
    check("rst_acc", 32'(acc_out), 32'(4'h0));
    check("rst_ext_a", 32'(ext_a), 32'(4'h0));
    check("rst_ext_b", 32'(ext_b), 32'(4'h0));
    check("rst_ext_cin", 32'(ext_cin), 32'(1'b0));
    check("rst_busy", 32'(busy), 32'(1'b0));
    check("rst_in_ready", 32'(in_ready), 32'(1'b1));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Add 5+3 into an idle DUT: accept edge, pop edge, then valid
    out_ready = 1'b1;
    push(1'b0, 1'b0, 4'd5, 4'd3, w);
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency_from_accept", 32'(lat), 32'(2));
    drain();

    // Subtract in both directions
    push(1'b1, 1'b0, 4'd5, 4'd3, w);
    push(1'b1, 1'b0, 4'd3, 4'd5, w);
    drain();

    // Accumulator chain: +4, +4, -8 (a operand ignored)
    check("acc_before_chain", 32'(acc_out), 32'(4'h0));
    push(1'b0, 1'b1, 4'd9, 4'd4, w);
    push(1'b0, 1'b1, 4'd1, 4'd4, w);
    push(1'b1, 1'b1, 4'd7, 4'd8, w);
    drain();
    check("acc_after_chain", 32'(acc_out), 32'(4'h0));

    // Unsigned overflow/underflow (saturating or wrapping per build)
    push(1'b0, 1'b0, 4'd15, 4'd1, w);
    push(1'b1, 1'b0, 4'd2, 4'd7, w);
    drain();

    // Backpressure: 1 in flight + 4 queued, then the 6th must wait
    out_ready = 1'b0;
    push(1'b0, 1'b0, 4'd1, 4'd2, w);
    push(1'b1, 1'b0, 4'd9, 4'd4, w);
    push(1'b0, 1'b0, 4'd7, 4'd7, w);
    push(1'b1, 1'b0, 4'd0, 4'd1, w);
    push(1'b0, 1'b0, 4'd8, 4'd8, w);
    @(negedge clk);
    check("full_in_ready", 32'(in_ready), 32'(1'b0));
    check("full_busy", 32'(busy), 32'(1'b1));
    fork
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join_none
    push(1'b1, 1'b0, 4'd15, 4'd15, w);
    check("sixth_held", 32'(w >= 3), 32'(1'b1));
    drain();

    // Reset while a command is in EXEC with 3 more queued
    out_ready = 1'b0;
    push(1'b0, 1'b1, 4'd0, 4'd3, w);
    push(1'b0, 1'b1, 4'd0, 4'd3, w);
    push(1'b0, 1'b1, 4'd0, 4'd3, w);
    push(1'b0, 1'b1, 4'd0, 4'd3, w);
    push(1'b0, 1'b1, 4'd0, 4'd3, w);
    out_ready = 1'b1;
    @(posedge clk);  // first result handed over, FSM back to IDLE
    #1;
    out_ready = 1'b0;
    @(posedge clk);  // next command popped, now in EXEC
    #1;
    check("pre_rst_busy", 32'(busy), 32'(1'b1));
    check("pre_rst_acc", 32'(acc_out), 32'(4'd3));
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    acc_m = '0;
    check("mid_rst_out_valid", 32'(out_valid), 32'(1'b0));
    check("mid_rst_out_flags", 32'({out_result, out_carry, out_zero, out_ovf}), 32'(7'h0));
    check("mid_rst_acc", 32'(acc_out), 32'(4'h0));
    check("mid_rst_ext", 32'({ext_a, ext_b, ext_cin}), 32'(9'h0));
    check("mid_rst_busy", 32'(busy), 32'(1'b0));
    check("mid_rst_in_ready", 32'(in_ready), 32'(1'b1));
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_no_output", 32'(out_valid), 32'(1'b0));
    check("post_rst_idle", 32'(busy), 32'(1'b0));

    // Normal operation after reset
    push(1'b0, 1'b1, 4'd0, 4'd2, w);
    push(1'b0, 1'b0, 4'd2, 4'd2, w);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
